serv_alu_seq: RTL and testbench
===============================

# serv_alu_seq

Operand sequencer and result collector for the bit-serial ALU. It accepts two parallel operands over a valid/ready handshake and streams them LSB-first as serial rs1/rs2 bits, with the enable, init, shift-amount-enable and count-done strobes the ALU expects. It then reassembles the serial rd stream and the compare flag into a parallel result with its own valid/ready handshake. It sits between a parallel register/test front end and the serial ALU datapath.

## Interface
- W, 32, operand/result width; power of two, ≥ 8
- clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  operand request valid
- o_ready  out  1  sequencer idle, can accept operands
- i_rs1  in  W  operand A
- i_rs2  in  W  operand B
- i_two_stage  in  1  run init pass (shift-amount load) before run pass
- o_rs1  out  1  serial operand A bit
- o_rs2  out  1  serial operand B bit
- o_en  out  1  run-pass enable to ALU
- o_init  out  1  init-pass strobe to ALU
- o_shamt_en  out  1  shift-amount capture enable (first 5 init cycles)
- o_cnt_done  out  1  last bit of run pass
- i_rd  in  1  serial result bit from ALU
- i_cmp  in  1  compare result from ALU
- o_valid  out  1  result valid
- i_ready  in  1  result consumer ready
- o_result  out  W  collected result
- o_cmp  out  1  captured compare flag

## Operation
- States: IDLE, INIT, RUN, DONE. Bit counter cnt, log2(W) bits.
- IDLE: o_ready=1. On i_valid&o_ready, load rs1/rs2 shift registers, clear cnt, latch i_two_stage. Next state is INIT if i_two_stage, else RUN. i_valid is ignored in any other state.
- o_rs1/o_rs2 = bit 0 of the respective shift register in every state. Both registers rotate right by one (bit 0 → bit W-1) each INIT and RUN cycle.
- INIT: o_init=1, o_en=0, o_shamt_en=1 while cnt<5. At cnt=W-1, go to RUN with cnt=0. After W rotations both operands are restored for the run pass.
- RUN: o_en=1; o_cnt_done=1 only when cnt=W-1. Each cycle result <= {i_rd, result[W-1:1]}. At cnt=W-1, o_cmp <= i_cmp and the state goes to DONE.
- DONE: o_valid=1; o_result and o_cmp held stable. On i_ready, go to IDLE. There is no bypass: a new request is accepted no earlier than the cycle after the DONE→IDLE transition.
- The counter wraps from W-1 to 0 at every pass boundary.
- o_en, o_init, o_shamt_en and o_cnt_done are decoded from registered state and cnt only, with no combinational path from inputs.
- Asserting i_rst_n low in any state aborts the operation immediately. All registers clear and the state becomes IDLE.

## Timing
- Reset values: state IDLE, cnt 0, o_ready 1, all other outputs 0, o_result 0, o_cmp 0.
- Accept at edge T0 (i_valid&o_ready sampled high).
- Single pass: RUN occupies cycles T0+1..T0+W; o_valid rises at T0+W+1.
- Two stage: INIT occupies T0+1..T0+W; RUN occupies T0+W+1..T0+2W; o_valid rises at T0+2W+1.
- i_rd is sampled in the same cycle as the o_rs1/o_rs2 bits it corresponds to; the ALU is combinational per bit.
- i_cmp is sampled only on the o_cnt_done cycle.
- o_ready falls the cycle after acceptance and returns the cycle after the o_valid&i_ready handshake.
- Minimum request-to-request spacing: W+2 cycles (single pass), 2W+2 cycles (two stage).

## Test plan
- Add loopback, W=32: bench adder model on o_rs1/o_rs2 with carry, i_rs1=0x00000005, i_rs2=0x00000003 → o_result=0x00000008, o_valid at T0+33, o_cnt_done high exactly one cycle (T0+32).
- Bit order: i_rs1=0x80000001, i_rd driven from o_rs1 → o_rs1 sequence 1, thirty 0s, 1; o_result=0x80000001.
- Two stage: i_rs2=0x0000001F, i_two_stage=1 → o_init high 32 cycles; o_shamt_en high first 5 with o_rs2=1 each; run-pass o_rs2 again 1×5 then 0s; o_valid at T0+65.
- Backpressure: hold i_ready=0 for 10 cycles after o_valid, pulsing i_valid → o_result/o_cmp stable, o_ready=0, no new request accepted; i_ready=1 → o_ready=1 next cycle.
- Compare capture: i_cmp=1 only on the o_cnt_done cycle, 0 elsewhere → o_cmp=1; repeat with i_cmp=1 everywhere except that cycle → o_cmp=0.
- Reset mid-RUN at cnt=10: assert i_rst_n low → all outputs 0 and o_ready=1 asynchronously. After release, a new add of 0x1+0x1 returns 0x00000002.

Source files
------------

// File: rtl/serv_alu_seq.sv
// Operand sequencer and result collector for the bit-serial ALU.
// Streams parallel operands LSB-first and reassembles the serial result.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for operands, o_ready high
// INIT  | shift-amount pass, operands rotate once around and are restored
// RUN   | run pass, ALU enabled, result collected from i_rd
// DONE  | result valid, held until the consumer takes it
module serv_alu_seq #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_rs1,
    input  logic [W-1:0] i_rs2,
    input  logic         i_two_stage,
    output logic         o_rs1,
    output logic         o_rs2,
    output logic         o_en,
    output logic         o_init,
    output logic         o_shamt_en,
    output logic         o_cnt_done,
    input  logic         i_rd,
    input  logic         i_cmp,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_result,
    output logic         o_cmp
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_rs1;
    logic [W-1:0]    r_rs2;
    logic [W-1:0]    r_result;
    logic            r_cmp;
    logic            w_accept;
    logic            w_cnt_last;
    logic            w_shift;

    assign w_cnt_last = (r_cnt == CW'(W - 1));
    assign w_accept   = (r_state == S_IDLE) && i_valid;
    assign w_shift    = (r_state == S_INIT) || (r_state == S_RUN);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (i_valid) w_state_nxt = i_two_stage ? S_INIT : S_RUN;
            S_INIT: if (w_cnt_last) w_state_nxt = S_RUN;
            S_RUN:  if (w_cnt_last) w_state_nxt = S_DONE;
            S_DONE: if (i_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_result <= '0;
            r_cmp    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_rs1 <= i_rs1;
                r_rs2 <= i_rs2;
                r_cnt <= '0;
            end else if (w_shift) begin
                // Rotation rather than shift so a full init pass leaves the
                // operands intact for the run pass; cnt wraps at W-1.
                r_rs1 <= {r_rs1[0], r_rs1[W-1:1]};
                r_rs2 <= {r_rs2[0], r_rs2[W-1:1]};
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_RUN) begin
                r_result <= {i_rd, r_result[W-1:1]};
                if (w_cnt_last) r_cmp <= i_cmp;
            end
        end
    end

    assign o_ready    = (r_state == S_IDLE);
    assign o_valid    = (r_state == S_DONE);
    assign o_en       = (r_state == S_RUN);
    assign o_init     = (r_state == S_INIT);
    assign o_shamt_en = (r_state == S_INIT) && (r_cnt < CW'(5));
    assign o_cnt_done = (r_state == S_RUN) && w_cnt_last;
    assign o_rs1      = r_rs1[0];
    assign o_rs2      = r_rs2[0];
    assign o_result   = r_result;
    assign o_cmp      = r_cmp;

endmodule

// File: tb/tb_serv_alu_seq.sv
// Directed testbench for serv_alu_seq with a bench-side serial adder model.
module tb_serv_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic [W-1:0] i_rs1 = '0;
    logic [W-1:0] i_rs2 = '0;
    logic         i_two_stage = 1'b0;
    logic         o_rs1, o_rs2, o_en, o_init, o_shamt_en, o_cnt_done;
    logic         i_rd, i_cmp;
    logic         o_valid;
    logic         i_ready = 1'b0;
    logic [W-1:0] o_result;
    logic         o_cmp;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           rd_mode = 0;   // 0 adder, 1 loopback rs1
    int           cmp_mode = 0;  // 0 zero, 1 only on cnt_done, 2 all but cnt_done
    logic         carry = 1'b0;

    serv_alu_seq #(.W(W)) dut (
        .clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_two_stage(i_two_stage),
        .o_rs1(o_rs1), .o_rs2(o_rs2), .o_en(o_en), .o_init(o_init),
        .o_shamt_en(o_shamt_en), .o_cnt_done(o_cnt_done),
        .i_rd(i_rd), .i_cmp(i_cmp), .o_valid(o_valid), .i_ready(i_ready),
        .o_result(o_result), .o_cmp(o_cmp)
    );

    always #5 clk = ~clk;

    assign i_rd  = (rd_mode == 1) ? o_rs1 : (o_rs1 ^ o_rs2 ^ carry);
    assign i_cmp = (cmp_mode == 1) ? o_cnt_done : (cmp_mode == 2) ? ~o_cnt_done : 1'b0;

    always @(posedge clk)
        carry <= o_en ? ((o_rs1 & o_rs2) | (carry & (o_rs1 ^ o_rs2))) : 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Presents one request; returns after the accepting edge (cycle k=1).
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic two);
        int n = 0;
        while (!o_ready && n < 200) begin tick(); n++; end
        n_cmp++;
        if (!o_ready) begin n_bad++; $display("FAIL issue_ready: o_ready stuck at 0, expected 1"); end
        i_rs1 = a; i_rs2 = b; i_two_stage = two; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic release_result();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    task automatic wait_valid(output int k);
        k = 1;
        while (!o_valid && k < 200) begin tick(); k++; end
        n_cmp++;
        if (!o_valid) begin n_bad++; $display("FAIL wait_valid: o_valid never rose, got 0 expected 1"); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        chk("rst_ready", {31'd0, o_ready}, 1);
        chk("rst_strobes", {26'd0, o_en, o_init, o_shamt_en, o_cnt_done, o_valid, o_cmp}, 0);
        chk("rst_serial", {30'd0, o_rs1, o_rs2}, 0);
        chk("rst_result", o_result, 0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        int k, vk, dk, dn;
        rd_mode = 0; cmp_mode = 0;
        issue(32'h5, 32'h3, 1'b0);
        k = 1; vk = 0; dk = 0; dn = 0;
        while (k < 60 && vk == 0) begin
            if (o_cnt_done) begin dn++; dk = k; end
            if (o_valid) vk = k;
            else begin tick(); k++; end
        end
        chk("add_result", o_result, 32'h8);
        chk("add_valid_cycle", vk, 33);
        chk("add_done_count", dn, 1);
        chk("add_done_cycle", dk, 32);
        chk("add_ready_low", {31'd0, o_ready}, 0);
        release_result();
        chk("add_ready_back", {30'd0, o_ready, o_valid}, 2'b10);
    endtask

    task automatic test_bit_order();
        logic [W-1:0] seq;
        int idx, k;
        rd_mode = 1;
        issue(32'h8000_0001, 32'h0, 1'b0);
        seq = '0; idx = 0;
        for (int c = 0; c < 40; c++) begin
            if (o_en && idx < W) begin seq[idx] = o_rs1; idx++; end
            if (o_valid) break;
            tick();
        end
        chk("bit_seq", seq, 32'h8000_0001);
        wait_valid(k);
        chk("bit_result", o_result, 32'h8000_0001);
        release_result();
        rd_mode = 0;
    endtask

    task automatic test_two_stage();
        logic [W-1:0] seq;
        int k, vk, ni, ns, idx, init_bad, sh_bad;
        issue(32'h0, 32'h1F, 1'b1);
        k = 1; vk = 0; ni = 0; ns = 0; idx = 0; init_bad = 0; sh_bad = 0; seq = '0;
        while (k < 100 && vk == 0) begin
            if (o_init) begin
                ni++;
                if (k > 32) init_bad++;
            end
            if (o_shamt_en) begin
                ns++;
                if (!o_rs2 || k > 5) sh_bad++;
            end
            if (o_en && idx < W) begin seq[idx] = o_rs2; idx++; end
            if (o_valid) vk = k;
            else begin tick(); k++; end
        end
        chk("ts_init_count", ni, 32);
        chk("ts_init_window", init_bad, 0);
        chk("ts_shamt_count", ns, 5);
        chk("ts_shamt_bits", sh_bad, 0);
        chk("ts_run_rs2", seq, 32'h1F);
        chk("ts_valid_cycle", vk, 65);
        chk("ts_result", o_result, 32'h1F);
        release_result();
    endtask

    task automatic test_backpressure();
        int k, bad;
        cmp_mode = 1;
        issue(32'h5, 32'h3, 1'b0);
        wait_valid(k);
        bad = 0;
        i_rs1 = 32'hDEAD_BEEF; i_rs2 = 32'h1234_5678;
        for (int c = 0; c < 10; c++) begin
            i_valid = 1'b1;
            tick();
            if (o_result !== 32'h8 || o_cmp !== 1'b1 || o_ready !== 1'b0 || o_valid !== 1'b1) bad++;
        end
        i_valid = 1'b0;
        chk("bp_hold_errors", bad, 0);
        chk("bp_result", o_result, 32'h8);
        release_result();
        chk("bp_ready_back", {30'd0, o_ready, o_valid}, 2'b10);
        tick();
        chk("bp_no_accept", {31'd0, o_ready}, 1);
        cmp_mode = 0;
    endtask

    task automatic test_cmp();
        int k;
        cmp_mode = 1;
        issue(32'h1, 32'h2, 1'b0);
        wait_valid(k);
        chk("cmp_set", {31'd0, o_cmp}, 1);
        release_result();
        cmp_mode = 2;
        issue(32'h1, 32'h2, 1'b0);
        wait_valid(k);
        chk("cmp_clear", {31'd0, o_cmp}, 0);
        release_result();
        cmp_mode = 0;
    endtask

    task automatic test_back_to_back();
        int k;
        issue(32'h1234_0000, 32'h0000_5678, 1'b0);
        wait_valid(k);
        chk("b2b_first", o_result, 32'h1234_5678);
        release_result();
        issue(32'hFFFF_FFFF, 32'h1, 1'b1);
        wait_valid(k);
        chk("b2b_second", o_result, 32'h0);
        release_result();
    endtask

    task automatic test_reset_mid_run();
        int k;
        issue(32'h0000_FFFF, 32'h0, 1'b0);
        for (int c = 0; c < 10; c++) tick();
        chk("mid_in_run", {31'd0, o_en}, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, o_ready}, 1);
        chk("mid_rst_strobes", {26'd0, o_en, o_init, o_shamt_en, o_cnt_done, o_valid, o_cmp}, 0);
        chk("mid_rst_data", {o_result[W-1:2], o_rs1, o_rs2}, 0);
        #3;
        rst_n = 1'b1;
        tick();
        issue(32'h1, 32'h1, 1'b0);
        wait_valid(k);
        chk("mid_after_add", o_result, 32'h2);
        chk("mid_after_cycle", k, 33);
        release_result();
    endtask

    initial begin
        test_reset();
        test_add();
        test_bit_order();
        test_two_stage();
        test_backpressure();
        test_cmp();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
